// File: rtl/fir_mac_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | fir_mac_sequencer_if : sample, coefficient, MAC and output bus bundle       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fir_mac_sequencer_if #(
  parameter int AW = 3
) ();
  logic [15:0]   sample_i;
  logic          sample_valid_i;
  logic          sample_ready_o;
  logic          coef_we_i;
  logic [AW-1:0] coef_addr_i;
  logic [15:0]   coef_data_i;
  logic          mac_clk_en_o;
  logic          mac_rst_o;
  logic [15:0]   mac_a_o;
  logic [15:0]   mac_b_o;
  logic [32:0]   mac_result_i;
  logic [15:0]   out_data_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          busy_o;

  modport slave (
    input  sample_i, sample_valid_i, coef_we_i, coef_addr_i, coef_data_i,
           mac_result_i, out_ready_i,
    output sample_ready_o, mac_clk_en_o, mac_rst_o, mac_a_o, mac_b_o,
           out_data_o, out_valid_o, busy_o
  );

  modport master (
    output sample_i, sample_valid_i, coef_we_i, coef_addr_i, coef_data_i,
           mac_result_i, out_ready_i,
    input  sample_ready_o, mac_clk_en_o, mac_rst_o, mac_a_o, mac_b_o,
           out_data_o, out_valid_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
// +----------------------------------------------------------------------------+
// | fir_mac_sequencer : streams delay-line/coefficient pairs into a free-running|
// | MAC and recovers the per-sample dot product.  Revision: 1.0                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module fir_mac_sequencer #(
  parameter int NTAPS   = 8,
  parameter int MAC_LAT = 3,
  parameter int SHIFT   = 15,
  parameter int AW      = $clog2(NTAPS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fir_mac_sequencer_if.slave   bus
);

  localparam int c_cnt_w = $clog2(NTAPS + MAC_LAT + 1);
  localparam logic [c_cnt_w-1:0] c_lat_last = c_cnt_w'(MAC_LAT - 1);
  localparam logic [c_cnt_w-1:0] c_tap_last = c_cnt_w'(NTAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
  logic [15:0]         r_mem  [NTAPS];
  logic [15:0]         r_coef [NTAPS];
  logic [AW-1:0]       r_head;
  logic [32:0]         r_base;
  logic [15:0]         r_out_data;
  logic                r_out_valid;
  logic                r_mac_rst;

  logic                w_accept;
  logic                w_base_load;
  logic                w_capture;
  logic [AW-1:0]       w_head_nxt;
  logic [AW-1:0]       w_tap;
  logic [AW-1:0]       w_rd_idx;
  logic [32:0]         w_diff;
  logic [32:0]         w_scaled;
  logic [15:0]         w_sat;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_base_load = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.sample_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = '0;
        end
      end
      S_FLUSH: begin
        if (r_cnt == c_lat_last) begin
          w_base_load = 1'b1;
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      S_RUN: begin
        if (r_cnt == c_tap_last) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      S_DRAIN: begin
        if (r_cnt == c_lat_last) begin
          w_capture   = 1'b1;
          w_state_nxt = S_OUT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      S_OUT: begin
        if (bus.out_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tap k pairs the k-th most recent sample with coef[k]; AW-bit wrap gives mod NTAPS.
  assign w_head_nxt = r_head + AW'(1);
  assign w_tap      = r_cnt[AW-1:0];
  assign w_rd_idx   = r_head - w_tap;

  // Modulo-2^33 difference survives accumulator wrap between baseline and capture.
  assign w_diff   = bus.mac_result_i - r_base;
  assign w_scaled = w_diff >> SHIFT;
  assign w_sat    = (w_scaled > 33'h0_0000_FFFF) ? 16'hFFFF : w_scaled[15:0];

  always_ff @(posedge clk_i) begin
    r_mac_rst <= rst_i;
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_head      <= '0;
      r_base      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        r_mem[i]  <= '0;
        r_coef[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (bus.coef_we_i && (r_state == S_IDLE)) r_coef[bus.coef_addr_i] <= bus.coef_data_i;
      if (w_accept) begin
        r_head             <= w_head_nxt;
        r_mem[w_head_nxt]  <= bus.sample_i;
      end
      if (w_base_load) r_base <= bus.mac_result_i;
      if (w_capture) begin
        r_out_data  <= w_sat;
        r_out_valid <= 1'b1;
      end else if ((r_state == S_OUT) && bus.out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.sample_ready_o = (r_state == S_IDLE);
  assign bus.busy_o         = (r_state != S_IDLE);
  assign bus.mac_clk_en_o   = (r_state != S_IDLE);
  assign bus.mac_rst_o      = r_mac_rst;
  assign bus.mac_a_o        = (r_state == S_RUN) ? r_mem[w_rd_idx] : 16'h0000;
  assign bus.mac_b_o        = (r_state == S_RUN) ? r_coef[w_tap]   : 16'h0000;
  assign bus.out_data_o     = r_out_data;
  assign bus.out_valid_o    = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_fir_mac_sequencer : directed vector bench with a 3-cycle MAC model       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fir_mac_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_mac_sequencer_if #(.AW(3)) bus ();

  fir_mac_sequencer #(
    .NTAPS(8), .MAC_LAT(3), .SHIFT(15), .AW(3)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Accumulating 16x16 MAC: operand register, product register, accumulator.
  logic [31:0] mac_p1, mac_p2;
  logic [32:0] mac_acc;
  bit          preset_req = 1'b0;
  logic [32:0] preset_val = '0;

  always @(posedge clk) begin
    if (bus.mac_rst_o) begin
      mac_p1  <= '0;
      mac_p2  <= '0;
      mac_acc <= '0;
    end else if (preset_req) begin
      mac_acc <= preset_val;
    end else if (bus.mac_clk_en_o) begin
      mac_p1  <= bus.mac_a_o * bus.mac_b_o;
      mac_p2  <= mac_p1;
      mac_acc <= mac_acc + {1'b0, mac_p2};
    end
  end
  assign bus.mac_result_i = mac_acc;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.sample_valid_i = 1'b0;
    bus.coef_we_i      = 1'b0;
    bus.out_ready_i    = 1'b0;
    @(posedge clk); #1;
    check("rst_valid", bus.out_valid_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_data", bus.out_data_o, 0);
    check("rst_ready", bus.sample_ready_o, 1);
    @(posedge clk); #1;
    check("rst_macrst", bus.mac_rst_o, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic write_coef(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus.coef_we_i   = 1'b1;
    bus.coef_addr_i = addr;
    bus.coef_data_i = data;
    @(negedge clk);
    bus.coef_we_i   = 1'b0;
  endtask

  task automatic load_coefs(input bit [1:0] mode);
    for (int i = 0; i < 8; i++) begin
      case (mode)
        2'd0:    write_coef(3'(i), (i == 0) ? 16'h8000 : 16'h0000);
        2'd1:    write_coef(3'(i), 16'h1000);
        default: write_coef(3'(i), 16'hFFFF);
      endcase
    end
  endtask

  // Accept one sample and count edges until out_valid_o; wr0 writes coef[0]=0x8000
  // on the accept edge, poke tries to zero coef[0] during RUN.
  task automatic send(input logic [15:0] s, input bit wr0, input bit poke, output int lat);
    @(negedge clk);
    bus.sample_i       = s;
    bus.sample_valid_i = 1'b1;
    if (wr0) begin
      bus.coef_we_i   = 1'b1;
      bus.coef_addr_i = 3'd0;
      bus.coef_data_i = 16'h8000;
    end
    @(posedge clk); #1;
    bus.sample_valid_i = 1'b0;
    bus.coef_we_i      = 1'b0;
    lat = 0;
    while (!bus.out_valid_o && lat < 100) begin
      if (poke && lat == 5) begin
        bus.coef_we_i   = 1'b1;
        bus.coef_addr_i = 3'd0;
        bus.coef_data_i = 16'h0000;
      end else begin
        bus.coef_we_i = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.coef_we_i = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    check("hs_valid_clr", bus.out_valid_o, 0);
    check("hs_idle", bus.busy_o, 0);
    @(negedge clk);
    bus.out_ready_i = 1'b0;
  endtask

  typedef struct {
    bit          do_reset;
    bit [1:0]    coef_mode;
    logic [15:0] sample;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int   lat;
    bit   hold_ok;
    bit   stale;
    logic [15:0] held;

    bus.sample_i       = '0;
    bus.sample_valid_i = 1'b0;
    bus.coef_we_i      = 1'b0;
    bus.coef_addr_i    = '0;
    bus.coef_data_i    = '0;
    bus.out_ready_i    = 1'b0;

    vecs[0] = '{1'b1, 2'd0, 16'd1000,  16'd1000};
    vecs[1] = '{1'b0, 2'd0, 16'd2000,  16'd2000};
    vecs[2] = '{1'b0, 2'd0, 16'd65535, 16'd65535};
    for (int i = 0; i < 10; i++)
      vecs[3+i] = '{(i == 0), 2'd1, 16'd800, (i < 8) ? 16'(100 * (i + 1)) : 16'd800};
    vecs[13] = '{1'b1, 2'd2, 16'hFFFF, 16'hFFFF};
    vecs[14] = '{1'b0, 2'd2, 16'hFFFF, 16'hFFFF};
    vecs[15] = '{1'b0, 2'd2, 16'd0,    16'hFFFF};

    repeat (2) @(posedge clk);
    for (int v = 0; v < 16; v++) begin
      if (vecs[v].do_reset) begin
        do_reset();
        load_coefs(vecs[v].coef_mode);
      end
      send(vecs[v].sample, 1'b0, 1'b0, lat);
      check($sformatf("vec%0d_latency", v), lat, 14);
      check($sformatf("vec%0d_data", v), bus.out_data_o, vecs[v].exp);
      handshake();
    end

    // Accumulator wrap between baseline and capture
    do_reset();
    load_coefs(2'd0);
    @(negedge clk);
    preset_val = 33'h1_FFFF_FF00;
    preset_req = 1'b1;
    @(negedge clk);
    preset_req = 1'b0;
    send(16'd500, 1'b0, 1'b0, lat);
    check("wrap_latency", lat, 14);
    check("wrap_data", bus.out_data_o, 16'd500);
    handshake();

    // Backpressure with an ignored mid-RUN coefficient write
    send(16'd4321, 1'b0, 1'b1, lat);
    check("bp_data", bus.out_data_o, 16'd4321);
    held    = bus.out_data_o;
    hold_ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_data_o !== held || bus.out_valid_o !== 1'b1 || bus.sample_ready_o !== 1'b0)
        hold_ok = 1'b0;
    end
    check("bp_hold", hold_ok, 1);
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", bus.sample_ready_o, 1);
    check("bp_release_valid", bus.out_valid_o, 0);
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    send(16'd3000, 1'b0, 1'b0, lat);
    check("bp_coef_kept", bus.out_data_o, 16'd3000);
    handshake();

    // Reset during RUN tap 3
    load_coefs(2'd1);
    @(negedge clk);
    bus.sample_i       = 16'd5000;
    bus.sample_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid_i = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("midrst_busy_before", bus.busy_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", bus.out_valid_o, 0);
    check("midrst_busy", bus.busy_o, 0);
    check("midrst_macrst", bus.mac_rst_o, 1);
    @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid_o !== 1'b0) stale = 1'b1;
    end
    check("midrst_no_pulse", stale, 0);
    // coef[0] written on the same edge the sample is accepted
    send(16'd1234, 1'b1, 1'b0, lat);
    check("midrst_latency", lat, 14);
    check("midrst_data", bus.out_data_o, 16'd1234);
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Upstream control stage for the 16x16 MAC (accumulating multiplier, 33-bit result, 3-cycle result latency, accumulator free-running and never cleared).
- Accepts unsigned 16-bit audio samples, keeps an NTAPS-deep circular delay line and a writable coefficient table, and streams sample/coefficient pairs into the MAC one tap per cycle.
- Recovers the per-sample dot product by subtracting a baseline snapshot of the MAC result, then scales, saturates and presents the filtered sample on a valid/ready output.

Parameters:
- NTAPS, 8, number of filter taps; power of two, range 2..64.
- MAC_LAT, 3, cycles from operands presented to updated value visible on mac_result_i.
- SHIFT, 15, right shift applied to the 33-bit dot product (Q1.15 coefficients, 0x8000 = 1.0).
- AW, $clog2(NTAPS), tap index width.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- sample_i  in  16  unsigned input sample.
- sample_valid_i  in  1  input sample valid.
- sample_ready_o  out  1  block can accept a sample.
- coef_we_i  in  1  coefficient write strobe.
- coef_addr_i  in  AW  coefficient index.
- coef_data_i  in  16  unsigned coefficient value.
- mac_clk_en_o  out  1  MAC clock enable.
- mac_rst_o  out  1  MAC reset.
- mac_a_o  out  16  MAC operand A (sample).
- mac_b_o  out  16  MAC operand B (coefficient).
- mac_result_i  in  33  MAC accumulated result.
- out_data_o  out  16  filtered output sample.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  downstream accepts output.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- One clock (clk_i). rst_i is synchronous and active-high. On reset:
  - state = IDLE; out_valid_o = 0; out_data_o = 0; busy_o = 0.
  - Delay line and coefficient table cleared to 0; head pointer = 0; baseline = 0; tap counter = 0.
  - mac_rst_o = 1, registered copy of rst_i; 0 otherwise.
- States and transitions:
  - IDLE -> FLUSH: on sample_valid_i & sample_ready_o.
  - FLUSH, MAC_LAT cycles -> RUN.
  - RUN, NTAPS cycles -> DRAIN.
  - DRAIN, MAC_LAT cycles -> OUT.
  - OUT -> IDLE: when out_ready_i.
- sample_ready_o = 1 only in IDLE. OUT->IDLE costs one bubble cycle, so no accept happens in the same cycle as the output handshake.
- Accept edge: head <= head+1 (mod NTAPS); mem[head+1] <= sample_i.
- Operands:
  - In RUN tap k (k = 0..NTAPS-1): mac_a_o = mem[(head-k) mod NTAPS], mac_b_o = coef[k], both combinational from registers.
  - In all other states mac_a_o = mac_b_o = 0, so the accumulator holds steady.
- mac_clk_en_o = busy_o.
- Baseline: baseline <= mac_result_i on the edge ending the last FLUSH cycle.
- Result capture, on the edge ending the last DRAIN cycle:
  - diff = (mac_result_i - baseline) mod 2^33, giving correct results across accumulator wrap.
  - scaled = diff >> SHIFT.
  - out_data_o <= (scaled > 0xFFFF) ? 0xFFFF : scaled[15:0].
  - out_valid_o <= 1.
- Latency: out_valid_o rises 2*MAC_LAT+NTAPS cycles after the accepting edge (14 with defaults). Per-sample throughput is one sample every 2*MAC_LAT+NTAPS+2 cycles minimum.
- Output hold: out_data_o and out_valid_o stay stable while out_valid_o & !out_ready_i. out_valid_o clears on the handshake edge.
- Coefficient writes: applied only in IDLE; coef_we_i in any other state is ignored (no partial update mid-filter).
- Simultaneous coef_we_i and sample accept in IDLE: the coefficient write lands first and is used by that sample's computation.
- Delay-line wrap: head wraps NTAPS-1 -> 0; tap indexing is modulo NTAPS.
- Reset mid-operation (any state): immediate return to reset values; any in-flight result is discarded; no out_valid_o pulse.

Test Plan:
- Impulse coefficient: coef[0]=0x8000, others 0; samples 1000, 2000, 65535 -> outputs 1000, 2000, 65535; each out_valid_o exactly 14 cycles after its accept edge.
- Moving average: all coef=0x1000; constant sample 800 -> outputs 100, 200, ..., 800, then steady 800 after the 8th sample (delay-line wrap exercised beyond 8 samples).
- Saturation: all coef=0xFFFF, samples 0xFFFF -> out_data_o=0xFFFF.
- Accumulator wrap: MAC model accumulator preset to 0x1_FFFF_FF00, coef[0]=0x8000, sample 500 -> out 500.
- Backpressure and ignored write: hold out_ready_i=0 for 20 cycles -> out_data_o stable, sample_ready_o=0. coef_we_i pulsed during RUN -> table unchanged (verified on next sample). Release out_ready_i -> IDLE next cycle.
- Reset mid-RUN: assert rst_i at tap 3 -> next cycle out_valid_o=0, busy_o=0, mac_rst_o=1. After reload coef[0]=0x8000, sample 1234 -> output 1234 with no stale history.
